// File: rtl/usb_hs_tx.sv
// HS USB bit transmitter: SYNC/EOP framing, bit stuffing and NRZI, one line bit per clock.
// First SYNC bit one clock after the first byte is accepted; tx_ready drops while hold is full, in EOP and in GAP.
module usb_hs_tx #(
  parameter int unsigned IPG = 8
) (
  input  logic       clock_480,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       data_out,
  output logic       tx_en,
  output logic       tx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_GAP
  } state_t;

  localparam logic [7:0] IPG_CNT = 8'(IPG);

  state_t     state_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic [7:0] sr_q;
  logic [2:0] idx_q;
  logic [2:0] ones_q;
  logic [7:0] cnt_q;
  logic       stuff_last_q;
  logic       data_out_q;
  logic       tx_en_q;

  logic accept;
  logic sync_bit;
  logic bit_stuff;
  logic at_boundary;

  assign tx_ready  = reset && !hold_full_q && (state_q != S_EOP) && (state_q != S_GAP);
  assign accept    = tx_valid && tx_ready;
  assign data_out  = data_out_q;
  assign tx_en     = tx_en_q;
  assign tx_busy   = (state_q != S_IDLE);

  assign sync_bit  = (cnt_q[4:0] == 5'd31);
  assign bit_stuff = (ones_q == 3'd6);
  // A byte ends after bit 7, or after the stuff bit owed behind bit 7.
  assign at_boundary = bit_stuff ? stuff_last_q
                                 : ((idx_q == 3'd7) && !(sr_q[0] && (ones_q == 3'd5)));

  always_ff @(posedge clock_480 or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      hold_q       <= 8'h00;
      hold_full_q  <= 1'b0;
      sr_q         <= 8'h00;
      idx_q        <= 3'd0;
      ones_q       <= 3'd0;
      cnt_q        <= 8'd0;
      stuff_last_q <= 1'b0;
      data_out_q   <= 1'b1;
      tx_en_q      <= 1'b0;
    end else begin
      if (accept) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          tx_en_q    <= 1'b0;
          data_out_q <= 1'b1;
          if (accept) begin
            state_q <= S_SYNC;
            cnt_q   <= 8'd0;
            ones_q  <= 3'd0;
          end
        end
        S_SYNC: begin
          tx_en_q <= 1'b1;
          if (!sync_bit) data_out_q <= ~data_out_q;
          ones_q <= sync_bit ? 3'd1 : 3'd0;
          if (sync_bit) begin
            sr_q         <= hold_q;
            hold_full_q  <= accept;
            idx_q        <= 3'd0;
            stuff_last_q <= 1'b0;
            state_q      <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DATA: begin
          tx_en_q <= 1'b1;
          if (bit_stuff) begin
            data_out_q <= ~data_out_q;
            ones_q     <= 3'd0;
          end else begin
            if (!sr_q[0]) data_out_q <= ~data_out_q;
            ones_q <= sr_q[0] ? (ones_q + 3'd1) : 3'd0;
            sr_q   <= {1'b0, sr_q[7:1]};
            idx_q  <= idx_q + 3'd1;
            if (idx_q == 3'd7 && !at_boundary) stuff_last_q <= 1'b1;
          end
          if (at_boundary) begin
            stuff_last_q <= 1'b0;
            idx_q        <= 3'd0;
            if (hold_full_q) begin
              sr_q        <= hold_q;
              hold_full_q <= accept;
            end else if (accept) begin
              // A byte arriving exactly on the boundary still belongs to this packet.
              sr_q        <= tx_data;
              hold_full_q <= 1'b0;
            end else begin
              state_q <= S_EOP;
              cnt_q   <= 8'd0;
            end
          end
        end
        S_EOP: begin
          tx_en_q <= 1'b1;
          if (cnt_q[2:0] == 3'd0) data_out_q <= ~data_out_q;
          if (cnt_q[2:0] == 3'd7) begin
            state_q <= S_GAP;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_GAP: begin
          tx_en_q    <= 1'b0;
          data_out_q <= 1'b1;
          if (cnt_q == IPG_CNT) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
